mem_access_ctrl: RTL and testbench

//  Initiator side of the word-addressed RAM interface (read/write/address/data_in/data_out).

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl_mdr_reg.sv | 20 ++
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 tb/tb_mem_access_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, sizes and FSM encoding for the RAM access controller.
package mem_ctrl_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned ADDRESS_WIDTH  = 9;
   localparam int unsigned MEM_SIZE       = 512;
   localparam int unsigned REQ_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshake plus RAM strobe bus; slave = controller, master = its environment.
interface mem_access_ctrl_if
   import mem_ctrl_pkg::*;
();

   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [REQ_ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_WIDTH-1:0]     rsp_rdata;
   logic                      rsp_err;
   logic                      mem_read;
   logic                      mem_write;
   logic [ADDRESS_WIDTH-1:0]  mem_address;
   logic [DATA_WIDTH-1:0]     mem_data_in;
   logic [DATA_WIDTH-1:0]     mem_data_out;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_read, mem_write, mem_address, mem_data_in
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_read, mem_write, mem_address, mem_data_in
   );

endinterface

// File: rtl/mem_access_ctrl_mdr_reg.sv
// Memory data register: load-capture from RAM wins over store data from the request.
module mdr_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_req,
   input  logic             ld_mem,
   input  logic [WIDTH-1:0] req_data,
   input  logic [WIDTH-1:0] mem_data,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q <= '0;
      else if (ld_mem) q <= mem_data;
      else if (ld_req) q <= req_data;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for a word-addressed RAM (IDLE -> ACCESS -> RESP).
// Optional MEM_BOUNDS_CHECK_EN: out-of-range requests skip the RAM and answer with rsp_err.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = mem_ctrl_pkg::DATA_WIDTH,
   parameter int unsigned ADDRESS_WIDTH = mem_ctrl_pkg::ADDRESS_WIDTH,
   parameter int unsigned MEM_SIZE      = mem_ctrl_pkg::MEM_SIZE
) (
   input  logic            Clock,
   input  logic            clear_n,
   mem_access_ctrl_if.slave bus
);

   state_t                   state, state_nxt;
   logic                     wr, wr_nxt;
   logic                     accept, capture, addr_err;
   logic                     req_ready_nxt, rsp_valid_nxt, mem_read_nxt, mem_write_nxt;
   logic [ADDRESS_WIDTH-1:0] mar;
   logic [DATA_WIDTH-1:0]    mdr;

`ifdef MEM_BOUNDS_CHECK_EN
   assign addr_err = (bus.req_addr >= REQ_ADDR_WIDTH'(MEM_SIZE));
`else
   logic unused_addr_hi;
   assign addr_err       = 1'b0;
   assign unused_addr_hi = ^{bus.req_addr[REQ_ADDR_WIDTH-1:ADDRESS_WIDTH], REQ_ADDR_WIDTH'(MEM_SIZE)};
`endif

   // Next state plus next values of the registered handshake/strobe outputs
   always_comb begin
      state_nxt = state;
      wr_nxt    = wr;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid && bus.req_ready) begin
               accept    = 1'b1;
               wr_nxt    = bus.req_write;
               state_nxt = addr_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            capture   = !wr;
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.rsp_valid && bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      req_ready_nxt = (state_nxt == IDLE);
      rsp_valid_nxt = (state_nxt == RESP);
      mem_write_nxt = (state_nxt == ACCESS) && wr_nxt;
      mem_read_nxt  = (state_nxt == ACCESS) && !wr_nxt;
   end

   always_ff @(posedge Clock or negedge clear_n) begin
      if (!clear_n) begin
         state         <= IDLE;
         wr            <= 1'b0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
      end else begin
         state         <= state_nxt;
         wr            <= wr_nxt;
         bus.req_ready <= req_ready_nxt;
         bus.rsp_valid <= rsp_valid_nxt;
         bus.mem_read  <= mem_read_nxt;
         bus.mem_write <= mem_write_nxt;
      end
   end

   // MAR: captured on accept, held through ACCESS
   always_ff @(posedge Clock or negedge clear_n) begin
      if (!clear_n)    mar <= '0;
      else if (accept) mar <= bus.req_addr[ADDRESS_WIDTH-1:0];
   end

   // Rejected requests load zero so the error response carries rdata = 0
   mdr_reg #(.WIDTH(DATA_WIDTH)) u_mdr (
      .clk      (Clock),
      .rst_n    (clear_n),
      .ld_req   (accept && (bus.req_write || addr_err)),
      .ld_mem   (capture),
      .req_data (addr_err ? '0 : bus.req_wdata),
      .mem_data (bus.mem_data_out),
      .q        (mdr)
   );

`ifdef MEM_BOUNDS_CHECK_EN
   always_ff @(posedge Clock or negedge clear_n) begin
      if (!clear_n)                                      bus.rsp_err <= 1'b0;
      else if (accept)                                   bus.rsp_err <= addr_err;
      else if ((state == RESP) && bus.rsp_ready)         bus.rsp_err <= 1'b0;
   end
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.mem_address = mar;
   assign bus.mem_data_in = mdr;
   assign bus.rsp_rdata   = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural RAM responder (writes/reads on falling edge).
module tb_mem_access_ctrl;

   localparam int unsigned DW    = mem_ctrl_pkg::DATA_WIDTH;
   localparam int unsigned AW    = mem_ctrl_pkg::ADDRESS_WIDTH;
   localparam int unsigned WORDS = mem_ctrl_pkg::MEM_SIZE;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   logic Clock;
   logic clear_n;
   mem_access_ctrl_if bus();

   mem_access_ctrl dut (
      .Clock   (Clock),
      .clear_n (clear_n),
      .bus     (bus.slave)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   int            wr_pulses = 0;
   int            cyc = 0;
   int            last_acc = 0;
   exp_t          sb[$];
   logic [DW-1:0] ram     [WORDS];
   logic [DW-1:0] ref_mem [WORDS];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // RAM responder
   always @(negedge Clock) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_data_in;
      if (bus.mem_read)  bus.mem_data_out <= ram[bus.mem_address];
   end

   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (bus.mem_write) wr_pulses <= wr_pulses + 1;
   end

   // Strobe sanity on every cycle out of reset
   always @(negedge Clock) begin
      if (clear_n) begin
         chk("excl", 32'(bus.mem_read && bus.mem_write), 0);
         chk("strobe_ctx", 32'((bus.mem_read || bus.mem_write) && (bus.rsp_valid || bus.req_ready)), 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic out_of_range(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
      return a >= 32'(WORDS);
`else
      return 1'b0;
`endif
   endfunction

   task automatic xact(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                       input int stall, input bit gap_chk);
      exp_t          e;
      exp_t          got_e;
      logic          err;
      logic [AW-1:0] idx;
      int            n;
      int            wr0;
      logic [DW-1:0] held;
      err = out_of_range(a);
      idx = a[AW-1:0];
      if (err)    e.rdata = '0;
      else if (w) begin ref_mem[idx] = d; e.rdata = d; end
      else        e.rdata = ref_mem[idx];
      e.err = err;
      n = 0;
      while (!bus.req_ready && n < 16) begin @(negedge Clock); n++; end
      chk("ready", 32'(bus.req_ready), 1);
      sb.push_back(e);
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
      wr0 = wr_pulses;
      @(posedge Clock);
      #1;
      if (gap_chk) chk("gap", 32'(cyc - last_acc), 3);
      last_acc      = cyc;
      bus.req_valid = 1'b0;
      bus.rsp_ready = (stall == 0);
      @(negedge Clock);
      chk("wr_strobe", 32'(bus.mem_write), 32'(w && !err));
      chk("rd_strobe", 32'(bus.mem_read), 32'(!w && !err));
      chk("rsp_early", 32'(bus.rsp_valid), 32'(err));
      chk("rdy_busy", 32'(bus.req_ready), 0);
      if (!err) begin
         @(negedge Clock);
         chk("rsp_lat", 32'(bus.rsp_valid), 1);
      end
      held = bus.rsp_rdata;
      for (int i = 0; i < stall; i++) begin
         bus.req_valid = 1'b1; bus.req_write = !w; bus.req_addr = a ^ 32'h1; bus.req_wdata = ~d;
         @(negedge Clock);
         chk("hold_v", 32'(bus.rsp_valid), 1);
         chk("hold_d", bus.rsp_rdata, held);
         chk("hold_rdy", 32'(bus.req_ready), 0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
         got_e = sb.pop_front();
         chk("rdata", bus.rsp_rdata, got_e.rdata);
         chk("err", 32'(bus.rsp_err), 32'(got_e.err));
      end
      @(posedge Clock);
      @(negedge Clock);
      chk("idle_rdy", 32'(bus.req_ready), 1);
      chk("idle_rsp", 32'(bus.rsp_valid), 0);
      chk("wr_pulses", 32'(wr_pulses - wr0), 32'(w && !err));
   endtask

   initial begin
      logic seen;
      for (int i = 0; i < int'(WORDS); i++) begin ram[i] = '0; ref_mem[i] = '0; end
      clear_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge Clock);
      chk("rst_ready", 32'(bus.req_ready), 1);
      chk("rst_rsp", 32'(bus.rsp_valid), 0);
      chk("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
      chk("rst_mar", 32'(bus.mem_address), 0);
      chk("rst_mdr", bus.mem_data_in, 0);
      chk("rst_err", 32'(bus.rsp_err), 0);
      clear_n = 1'b1;
      @(negedge Clock);

      xact(1'b1, 32'h005, 32'hDEADBEEF, 0, 1'b0);
      xact(1'b0, 32'h005, '0, 0, 1'b0);

      xact(1'b1, 32'h000, 32'd1, 0, 1'b0);
      xact(1'b1, 32'h1FF, 32'd2, 0, 1'b1);
      xact(1'b0, 32'h000, '0, 0, 1'b1);
      xact(1'b0, 32'h1FF, '0, 0, 1'b1);

      xact(1'b0, 32'h005, '0, 5, 1'b0);

      // Reset while a store is in ACCESS: strobe drops at once, no response
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h00A; bus.req_wdata = 32'h12345678;
      @(posedge Clock);
      #1;
      bus.req_valid = 1'b0;
      chk("abort_pre", 32'(bus.mem_write), 1);
      clear_n = 1'b0;
      #1;
      chk("abort_wr", 32'(bus.mem_write), 0);
      chk("abort_rdy", 32'(bus.req_ready), 1);
      chk("abort_rsp", 32'(bus.rsp_valid), 0);
      @(negedge Clock);
      clear_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin @(negedge Clock); seen |= bus.rsp_valid; end
      chk("abort_no_rsp", 32'(seen), 0);
      xact(1'b0, 32'h00A, '0, 0, 1'b0);

      // Out-of-range store: error response when checked, aliases to 0x000 otherwise
      xact(1'b1, 32'h200, 32'hCAFEF00D, 0, 1'b0);
      xact(1'b0, 32'h000, '0, 0, 1'b0);

      for (int i = 0; i < 12; i++)
         xact(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), 32'($urandom), $urandom_range(0, 2), 1'b0);
      for (int i = 0; i < 4; i++)
         xact(1'b0, 32'(i * 100), '0, 0, 1'b0);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
